priority_arbiter_rr: RTL and testbench

Registered N-way request arbiter. It generalises the combinational 8-bit priority encoder into a parametrised, clocked block with two modes: fixed priority (highest index wins) and round-robin. It adds a grant-hold handshake and an optional maximum-hold preemption counter. It sits between N requesting agents and one shared resource, and drives a one-hot grant plus an encoded index.

---
 rtl/priority_arbiter_rr.sv | 78 +++++++
 tb/tb_priority_arbiter_rr.sv | 121 ++++++++++++
 2 files changed

// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr: registered N-way arbiter with fixed/round-robin modes, grant hold and max-hold preemption
module priority_arbiter_rr #(
  parameter int N = 8,
  parameter int MAX_HOLD = 0,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid,
  output logic          preempt
);
  localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HMAX = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d, last_q, last_d, start, win_idx;
  logic [CW-1:0] hold_q, hold_d;
  logic          preempt_q, preempt_d;
  // search descends from start-1 and wraps; iterating backwards leaves the first hit in win_idx
  always_comb begin
    start = mode ? last_q : '0;
    win_idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(start) + N - k) % N]) win_idx = IW'((int'(start) + N - k) % N);
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d = idx_q;
    last_d = last_q;
    hold_d = hold_q;
    preempt_d = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        grant_d = N'(1) << win_idx;
        idx_d = win_idx;
        last_d = win_idx;
        hold_d = '0;
      end
    end else if (!req[idx_q]) begin
      state_d = IDLE;
      grant_d = '0;
    end else if (MAX_HOLD != 0 && hold_q == HMAX && |(req & ~grant_q)) begin
      state_d = IDLE;
      grant_d = '0;
      preempt_d = 1'b1;
    end else begin
      hold_d = (MAX_HOLD != 0 && hold_q != HMAX) ? hold_q + 1'b1 : hold_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q <= '0;
      last_q <= '0;
      hold_q <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      last_q <= last_d;
      hold_q <= hold_d;
      preempt_q <= preempt_d;
    end
  end
  assign grant = grant_q;
  assign grant_idx = idx_q;
  assign grant_valid = (state_q == GRANT);
  assign preempt = preempt_q;
endmodule

// File: tb/tb_priority_arbiter_rr.sv
// tb_priority_arbiter_rr: directed and random stimulus checked against a cycle-level behavioural model
module tb_priority_arbiter_rr;
  localparam int N = 8;
  localparam int MH = 4;
  logic         clk = 0;
  logic         rst = 1;
  logic         mode = 0;
  logic [N-1:0] req = '1;
  logic [N-1:0] grant;
  logic [2:0]   grant_idx;
  logic         grant_valid;
  logic         preempt;
  int vectors = 0;
  int miscompares = 0;
  int m_owner, m_last, m_hold, m_idx;
  bit m_pre;
  priority_arbiter_rr #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .mode(mode), .req(req),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .preempt(preempt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 1; k <= N; k++)
      if (r[(start - k + N) % N]) return (start - k + N) % N;
    return 0;
  endfunction
  task automatic model_reset();
    m_owner = -1; m_last = 0; m_hold = 0; m_idx = 0; m_pre = 0;
  endtask
  task automatic check_all();
    chk("grant", 64'(grant), (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0);
    chk("grant_idx", 64'(grant_idx), 64'(m_idx));
    chk("grant_valid", 64'(grant_valid), 64'(m_owner >= 0));
    chk("preempt", 64'(preempt), 64'(m_pre));
  endtask
  task automatic step(input logic [N-1:0] r, input logic md);
    req = r;
    mode = md;
    @(posedge clk);
    m_pre = 0;
    if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = pick(r, md ? m_last : 0);
        m_idx = m_owner; m_last = m_owner; m_hold = 0;
      end
    end else if (!r[m_owner]) m_owner = -1;
    else if (m_hold == MH - 1 && (r & ~(N'(1) << m_owner)) != 0) begin
      m_owner = -1; m_pre = 1;
    end else if (m_hold < MH - 1) m_hold++;
    #1;
    check_all();
  endtask
  initial begin
    logic [N-1:0] r;
    int on_cycles;
    model_reset();
    #2;
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 0;
    step(8'hFF, 0);
    chk("reset_first_idx", 64'(grant_idx), 64'd7);
    step(8'h00, 0);
    step(8'h00, 0);
    step(8'b0010_1010, 0);
    chk("fixed_idx5", 64'(grant_idx), 64'd5);
    step(8'b0000_1010, 0);
    chk("release_bubble", 64'(grant_valid), 64'd0);
    step(8'b0000_1010, 0);
    chk("fixed_idx3", 64'(grant_idx), 64'd3);
    step(8'h00, 1);
    step(8'h00, 1);
    step(8'b0000_0010, 1);
    step(8'h00, 1);
    step(8'b0000_0101, 1);
    chk("rr_idx0", 64'(grant_idx), 64'd0);
    step(8'h00, 1);
    step(8'b1000_0101, 1);
    chk("rr_wrap_idx7", 64'(grant_idx), 64'd7);
    step(8'h00, 1);
    on_cycles = 0;
    for (int i = 0; i < 45; i++) begin
      step(8'hFF, 1);
      if (grant_valid) on_cycles++;
      if (preempt) begin
        chk("preempt_hold_len", 64'(on_cycles), 64'(MH));
        on_cycles = 0;
      end
    end
    step(8'h00, 1);
    for (int i = 0; i < 20; i++) step(8'b0000_0100, 0);
    chk("no_competitor_idx2", 64'(grant_idx), 64'd2);
    step(8'h00, 0);
    step(8'h00, 0);
    step(8'b0000_1000, 1);
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    #1 rst = 0;
    step(8'b0000_1010, 1);
    chk("post_reset_idx3", 64'(grant_idx), 64'd3);
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) r = N'($urandom) & N'($urandom);
      if ($urandom_range(15) == 0) r = '0;
      step(r, 1'($urandom_range(1)));
      chk("onehot", 64'($countones(grant) <= 1), 64'd1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
